// File: rtl/grant_decoder3to8_pkg.sv
// Shared types and defaults for the registered 3-to-8 grant decoder.
//   state_e     : controller states (idle, grant held, waiting for ack release)
//   N_OUT_DEF   : default number of grant lines
//   CODE_W      : default code width (log2 of N_OUT_DEF)
//   TIMEOUT_DEF : default grant hold limit in cycles (timeout build only)
package grant_dec_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } state_e;

  localparam int unsigned N_OUT_DEF   = 8;
  localparam int unsigned CODE_W      = 3;
  localparam int unsigned TIMEOUT_DEF = 16;

endpackage

// File: rtl/grant_decoder3to8_onehot_decode.sv
// Purely combinational binary-to-one-hot decoder.
//   code_i   : binary index
//   onehot_o : bit code_i set, all others clear (all-zero if code_i >= NOut)
import grant_dec_pkg::*;

module onehot_decode #(
  parameter int unsigned CodeW = CODE_W,
  parameter int unsigned NOut  = N_OUT_DEF
) (
  input  logic [CodeW-1:0] code_i,
  output logic [NOut-1:0]  onehot_o
);

  // Compare against every line index so a non-power-of-two NOut never indexes out of range.
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NOut; i++) begin
      if (code_i == CodeW'(i)) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/grant_decoder3to8.sv
// Registered grant decoder: accepts a code over valid/ready, drives a held one-hot grant to
// the addressed target and waits for a 4-phase ack (ack rises, then falls) before idling.
// Optional macro GRANT_DECODER_TIMEOUT_EN: abort a grant that is not acked within TIMEOUT
// cycles, pulsing timeout_err and returning straight to idle.
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : in_code is valid
//   in_code     : index of the line to grant
//   in_ready    : can accept a code (idle and not in reset)
//   ack         : per-line acknowledge; only the addressed bit is observed
//   out_grant   : registered one-hot grant, zero when not granting
//   busy        : transaction in progress (grant or release phase)
//   last_code   : most recently accepted code
//   timeout_err : one-cycle pulse on timeout abort (constant 0 without the macro)
import grant_dec_pkg::*;

module grant_decoder3to8 #(
  parameter int unsigned N_OUT   = N_OUT_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [$clog2(N_OUT)-1:0]   in_code,
  output logic                       in_ready,
  input  logic [N_OUT-1:0]           ack,
  output logic [N_OUT-1:0]           out_grant,
  output logic                       busy,
  output logic [$clog2(N_OUT)-1:0]   last_code,
  output logic                       timeout_err
);

  localparam int unsigned CodeW = $clog2(N_OUT);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("grant_decoder3to8: TIMEOUT must be at least 2");
  end

  state_e           state_q, state_d;
  logic [CodeW-1:0] code_q, code_d;
  logic [N_OUT-1:0] grant_q, grant_d;
  logic [N_OUT-1:0] dec_grant;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ack_sel;
  logic             timeout_hit;

  onehot_decode #(
    .CodeW (CodeW),
    .NOut  (N_OUT)
  ) u_onehot_decode (
    .code_i   (in_code),
    .onehot_o (dec_grant)
  );

  assign ack_sel  = ack[code_q];
  assign in_ready = (state_q == StIdle) & ~rst;

`ifdef GRANT_DECODER_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counter holds (grant cycles already elapsed - 1); reaching CntLast at an edge means the
  // grant has been visible for TIMEOUT cycles. Saturates so it can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && in_valid) begin
      cnt_d = '0;
    end else if (state_q == StGrant && cnt_q != CntLast) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (cnt_q == CntLast);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StGrant;
          code_d  = in_code;
          grant_d = dec_grant;
          busy_d  = 1'b1;
        end
      end
      StGrant: begin
        // A real ack wins over a timeout landing on the same edge.
        if (ack_sel) begin
          state_d = StRelease;
          grant_d = '0;
        end else if (timeout_hit) begin
          state_d = StIdle;
          grant_d = '0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      StRelease: begin
        if (!ack_sel) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      code_q  <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign out_grant   = grant_q;
  assign busy        = busy_q;
  assign last_code   = code_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_grant_decoder3to8.sv
module tb_grant_decoder3to8;

`ifdef GRANT_DECODER_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 16;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] ack;
  logic [7:0] out_grant;
  logic       busy;
  logic [2:0] last_code;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  grant_decoder3to8 #(
    .N_OUT   (8),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_code     (in_code),
    .in_ready    (in_ready),
    .ack         (ack),
    .out_grant   (out_grant),
    .busy        (busy),
    .last_code   (last_code),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] codes [3];
    codes[0] = 3'd0;
    codes[1] = 3'd7;
    codes[2] = 3'd3;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = 3'd0;
    ack      = 8'h00;
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_grant", 32'(out_grant), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_last", 32'(last_code), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(in_ready), 32'd1);

    // Accept code 5.
    in_valid = 1'b1;
    in_code  = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("c5_grant", 32'(out_grant), 32'h20);
    chk("c5_busy", 32'(busy), 32'd1);
    chk("c5_ready", 32'(in_ready), 32'd0);
    chk("c5_last", 32'(last_code), 32'd5);

    // Wrong-line ack must be ignored.
    ack = 8'h04;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrong_ack_grant", 32'(out_grant), 32'h20);
    end
    ack = 8'h20;
    tick();
    chk("ack_grant_drop", 32'(out_grant), 32'h00);
    chk("ack_busy", 32'(busy), 32'd1);
    chk("ack_ready", 32'(in_ready), 32'd0);
    tick();
    chk("rel_hold_ready", 32'(in_ready), 32'd0);
    chk("rel_hold_busy", 32'(busy), 32'd1);
    ack = 8'h00;
    tick();
    chk("rel_done_ready", 32'(in_ready), 32'd1);
    chk("rel_done_busy", 32'(busy), 32'd0);

    // Back-to-back codes 0, 7, 3: each accept, ack, release takes exactly 3 edges.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_code = codes[k];
      chk("b2b_ready_pre", 32'(in_ready), 32'd1);
      tick();
      chk("b2b_grant", 32'(out_grant), 32'(8'h01 << codes[k]));
      chk("b2b_last", 32'(last_code), 32'(codes[k]));
      chk("b2b_ready_busy", 32'(in_ready), 32'd0);
      ack = 8'h01 << codes[k];
      tick();
      chk("b2b_grant_drop", 32'(out_grant), 32'h00);
      chk("b2b_ready_rel", 32'(in_ready), 32'd0);
      ack = 8'h00;
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_end_ready", 32'(in_ready), 32'd1);
    chk("b2b_end_grant", 32'(out_grant), 32'h00);

    // Reset while granting code 2.
    in_valid = 1'b1;
    in_code  = 3'd2;
    tick();
    in_valid = 1'b0;
    chk("c2_grant", 32'(out_grant), 32'h04);
    rst = 1'b1;
    tick();
    chk("mid_rst_grant", 32'(out_grant), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_last", 32'(last_code), 32'd0);
    chk("mid_rst_err", 32'(timeout_err), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

`ifdef GRANT_DECODER_TIMEOUT_EN
    // Code 6, never acked: grant visible 4 cycles, then aborted.
    in_valid = 1'b1;
    in_code  = 3'd6;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_hold_grant", 32'(out_grant), 32'h40);
      chk("to_hold_err", 32'(timeout_err), 32'd0);
      tick();
    end
    chk("to_grant", 32'(out_grant), 32'h00);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_ready", 32'(in_ready), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    ack = 8'h40;
    tick();
    chk("to_err_pulse", 32'(timeout_err), 32'd0);
    chk("late_ack_ready", 32'(in_ready), 32'd1);
    chk("late_ack_busy", 32'(busy), 32'd0);
    chk("late_ack_grant", 32'(out_grant), 32'h00);
    tick();
    chk("late_ack_ready2", 32'(in_ready), 32'd1);
    ack = 8'h00;
    tick();
`else
    // Code 1, ack withheld 100 cycles: grant must be held with no error.
    in_valid = 1'b1;
    in_code  = 3'd1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      chk("hold_grant", 32'(out_grant), 32'h02);
      chk("hold_err", 32'(timeout_err), 32'd0);
      tick();
    end
    ack = 8'h02;
    tick();
    chk("hold_ack_grant", 32'(out_grant), 32'h00);
    ack = 8'h00;
    tick();
    chk("hold_end_ready", 32'(in_ready), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grant_decoder3to8.md
# grant_decoder3to8

Registered 3-to-8 grant decoder. It takes a 3-bit index over a valid/ready handshake and drives the matching one-hot grant line. The grant is held until the addressed target completes a 4-phase ack handshake. It sits downstream of `priority_encoder8to3`: it turns the winning request index back into a single held grant toward the requesting agent.

## Interface
Parameters:
- `N_OUT`, 8: number of grant lines. The code width is `$clog2(N_OUT)`, which is 3 at the default.
- `TIMEOUT`, 16: maximum number of cycles the grant is held waiting for ack. Minimum legal value is 2.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `in_valid`, input, 1: `in_code` is valid.
- `in_code`, input, 3: index of the line to grant.
- `in_ready`, output, 1: block can accept a code. High only in IDLE while `rst`=0.
- `ack`, input, 8: per-line acknowledge from targets.
- `out_grant`, output, 8: one-hot grant, registered. All-zero when idle.
- `busy`, output, 1: high in GRANT or RELEASE.
- `last_code`, output, 3: most recently accepted code.
- `timeout_err`, output, 1: one-cycle pulse on timeout abort. Tied to 0 when the macro is off.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - GRANT: `out_grant`=1<<code. Waiting for `ack[code]`=1.
  - RELEASE: grant dropped. Waiting for `ack[code]`=0.
- IDLE→GRANT: on `in_valid && in_ready`. Latch `in_code` into `code` and `last_code`, and load the timeout counter to 0.
- GRANT→RELEASE: when `ack[code]`=1 is sampled. `out_grant` goes to 0 on the same edge.
- RELEASE→IDLE: when `ack[code]`=0 is sampled.
- `ack` bits other than `ack[code]` are ignored in every state. `ack` seen in IDLE is ignored.
- `in_valid` is ignored while `in_ready`=0. No queuing: the upstream holds `in_code` stable until the handshake.
- `out_grant` is always zero or exactly one-hot. It is never multi-hot.
- Reset values: state IDLE; `out_grant`=0; `busy`=0; `last_code`=0; `timeout_err`=0; counter=0; `in_ready`=0 while `rst`=1.
- Reset mid-transaction: the grant drops at the reset edge and the block returns to IDLE. No `timeout_err` is raised.
- Timeout counter: `$clog2(TIMEOUT)` bits. It increments every GRANT cycle and saturates, so it never wraps.

## Timing
- Handshake at edge E: `out_grant` is asserted from E+1. `busy`=1 from E+1. `in_ready`=0 from E+1.
- Ack: the first edge A≥E+1 with `ack[code]`=1 clears `out_grant` after A.
- Release: the first edge R≥A+1 with `ack[code]`=0 returns to IDLE. `in_ready`=1 after R.
- Minimum transaction is 3 cycles, handshake to next `in_ready`. Back-to-back accepts are therefore at most 1 per 3 cycles.
- The combinational path is `in_ready` = (state==IDLE) & ~`rst` only. Every other output is registered.

## Configuration
- Macro: `GRANT_DECODER_TIMEOUT_EN`.
- Defined:
  - If `ack[code]` is still 0 after the grant has been held `TIMEOUT` cycles, `out_grant` clears on that edge.
  - `timeout_err` pulses for 1 cycle.
  - State goes directly to IDLE, skipping RELEASE.
  - A late ack is then ignored, because ack is ignored in IDLE.
- Undefined: no counter logic. The grant is held indefinitely until ack, and `timeout_err` is a constant 0.

## Structure
- Package `grant_dec_pkg` contains:
  - the state enum (IDLE, GRANT, RELEASE);
  - `N_OUT_DEF`=8;
  - `CODE_W`=3;
  - `TIMEOUT_DEF`=16.
- Sub-module `onehot_decode`: purely combinational, `CODE_W`→`N_OUT`, output = 1<<code. Instantiated once, and its output is registered into `out_grant`.

## Test plan
- Reset, then `in_valid`=1 with `in_code`=5. Expect `out_grant`=8'b0010_0000 one cycle later, `busy`=1, `in_ready`=0, `last_code`=5.
- In GRANT with code 5, drive `ack`=8'b0000_0100 (wrong line) for 4 cycles. The grant must stay 8'h20. Then drive `ack[5]`=1: grant goes to 0 next cycle. Hold ack high 2 cycles: the block stays in RELEASE. Drop ack: `in_ready`=1 next cycle.
- Back-to-back codes 0, 7, 3 with ack pulsed 1 cycle each. Expect grants 8'h01, 8'h80, 8'h08, with accepts spaced exactly 3 cycles apart.
- Assert `rst` for 1 cycle while in GRANT with code 2. Expect `out_grant`=0, `busy`=0, `last_code`=0, `timeout_err`=0 after the edge, and `in_ready`=1 the cycle after `rst` falls.
- With `GRANT_DECODER_TIMEOUT_EN` defined and `TIMEOUT`=4: accept code 6 and never ack. Expect the grant 8'h40 held 4 cycles, then 0 with a one-cycle `timeout_err`, and `in_ready`=1 on the same cycle. A subsequent `ack[6]` must cause no state change.
- With the macro undefined: accept code 1 and withhold ack for 100 cycles. The grant must stay 8'h02 and `timeout_err` must stay 0 throughout.
